// File: rtl/safe_pkg.sv
// Shared key codes and FSM state type for the keypad safe controller.
package safe_pkg;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_STAR  = 4'd11;
    localparam logic [3:0] KEY_NONE  = 4'd13;

    typedef enum logic [1:0] {
        OPEN_SET,
        OPEN_CONFIRM,
        LOCKED,
        LOCKOUT
    } safe_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/code_entry_buf.sv
// Entry buffer: collects up to CODE_LEN digits, digit 0 in the low nibble.
module code_entry_buf #(
    parameter int CODE_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    output logic [4*CODE_LEN-1:0] digits,
    output logic                  full
);

    localparam int IW = $clog2(CODE_LEN + 1);

    logic [IW-1:0]         idx_q, idx_d;
    logic [4*CODE_LEN-1:0] digits_q, digits_d;

    assign full   = (idx_q == IW'(CODE_LEN));
    assign digits = digits_q;

    always_comb begin
        idx_d    = idx_q;
        digits_d = digits_q;
        if (clr) begin
            idx_d = '0;
        end else if (digit_valid && !full) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                if (idx_q == IW'(i)) begin
                    digits_d[4*i +: 4] = digit;
                end
            end
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            digits_q <= '0;
        end else begin
            idx_q    <= idx_d;
            digits_q <= digits_d;
        end
    end

endmodule

// File: rtl/safe_lock_ctrl.sv
// Keypad safe controller: code set/confirm, lock/unlock, and timed
// lockout after MAX_FAILS consecutive wrong unlock attempts.
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     invalue,
    output logic                           lock,
    output logic                           green,
    output logic                           blue,
    output logic                           red,
    output logic [$clog2(MAX_FAILS+1)-1:0] fails
);

    localparam int IW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int CW = $clog2(LOCKOUT_CYCLES);

    safe_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*CODE_LEN-1:0] code_q, code_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         fails_q, fails_d;
    logic                  lock_q, lock_d;
    logic                  green_q, green_d;
    logic                  blue_q, blue_d;
    logic                  red_q, red_d;

    logic                  buf_clr;
    logic                  buf_wr;
    logic [4*CODE_LEN-1:0] buf_digits;
    logic                  buf_full;
    logic                  set_full;
    logic                  match;
    logic                  k_digit;
    logic                  k_enter;
    logic                  k_star;

    code_entry_buf #(
        .CODE_LEN(CODE_LEN)
    ) u_entry (
        .clk        (clk),
        .rst        (rst),
        .clr        (buf_clr),
        .digit_valid(buf_wr),
        .digit      (invalue),
        .digits     (buf_digits),
        .full       (buf_full)
    );

    assign set_full = (idx_q == IW'(CODE_LEN));
    assign match    = (buf_digits == code_q);
    assign k_digit  = is_digit(invalue);
    assign k_enter  = (invalue == KEY_ENTER);
    assign k_star   = (invalue == KEY_STAR);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fails_d = fails_q;
        lock_d  = lock_q;
        green_d = green_q;
        blue_d  = blue_q;
        red_d   = red_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        unique case (state_q)
            OPEN_SET: begin
                if (k_digit && !set_full) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (idx_q == IW'(i)) begin
                            code_d[4*i +: 4] = invalue;
                        end
                    end
                    idx_d = idx_q + IW'(1);
                end else if (k_star) begin
                    idx_d = '0;
                end else if (k_enter && set_full) begin
                    state_d = OPEN_CONFIRM;
                    idx_d   = '0;
                    buf_clr = 1'b1;
                end
            end
            OPEN_CONFIRM: begin
                if (k_digit && !buf_full) begin
                    buf_wr = 1'b1;
                    idx_d  = idx_q + IW'(1);
                end else if (k_star) begin
                    state_d = OPEN_SET;
                    idx_d   = '0;
                    buf_clr = 1'b1;
                end else if (k_enter && buf_full) begin
                    idx_d   = '0;
                    buf_clr = 1'b1;
                    if (match) begin
                        state_d = LOCKED;
                        lock_d  = 1'b1;
                        blue_d  = 1'b1;
                        green_d = 1'b0;
                    end else begin
                        state_d = OPEN_SET;
                    end
                end
            end
            LOCKED: begin
                if (k_digit && !buf_full) begin
                    buf_wr = 1'b1;
                    idx_d  = idx_q + IW'(1);
                end else if (k_star) begin
                    idx_d   = '0;
                    buf_clr = 1'b1;
                end else if (k_enter && buf_full) begin
                    idx_d   = '0;
                    buf_clr = 1'b1;
                    if (match) begin
                        state_d = OPEN_SET;
                        lock_d  = 1'b0;
                        green_d = 1'b1;
                        blue_d  = 1'b0;
                        fails_d = '0;
                    end else begin
                        fails_d = fails_q + FW'(1);
                        if (fails_d == FW'(MAX_FAILS)) begin
                            state_d = LOCKOUT;
                            cnt_d   = CW'(LOCKOUT_CYCLES - 1);
                            red_d   = 1'b1;
                            blue_d  = 1'b0;
                            lock_d  = 1'b1;
                        end
                    end
                end
            end
            LOCKOUT: begin
                // Keys are dropped here, including on the exit edge.
                if (cnt_q == '0) begin
                    state_d = LOCKED;
                    fails_d = '0;
                    red_d   = 1'b0;
                    blue_d  = 1'b1;
                    idx_d   = '0;
                    buf_clr = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OPEN_SET;
            idx_q   <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            fails_q <= '0;
            lock_q  <= 1'b0;
            green_q <= 1'b1;
            blue_q  <= 1'b0;
            red_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fails_q <= fails_d;
            lock_q  <= lock_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            red_q   <= red_d;
        end
    end

    assign lock  = lock_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign red   = red_q;
    assign fails = fails_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed plus random bench for safe_lock_ctrl against a queue-based
// behavioural model of the safe.
module tb_safe_lock_ctrl;

    localparam int CL = 4;
    localparam int MF = 3;
    localparam int LC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] invalue = 4'd13;
    logic       lock, green, blue, red;
    logic [1:0] fails;

    int vectors = 0;
    int miscompares = 0;

    safe_lock_ctrl #(
        .CODE_LEN      (CL),
        .MAX_FAILS     (MF),
        .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .invalue(invalue),
        .lock   (lock),
        .green  (green),
        .blue   (blue),
        .red    (red),
        .fails  (fails)
    );

    always #5 clk = ~clk;

    typedef enum {M_SET, M_CONF, M_LOCKED, M_OUT} mode_t;

    mode_t m_mode;
    int    m_code[$];
    int    m_entry[$];
    int    m_fails;
    int    m_left;
    bit    m_lock, m_green, m_blue, m_red;

    function automatic bit same_code();
        if (m_code.size() != m_entry.size()) return 1'b0;
        foreach (m_code[i]) if (m_code[i] != m_entry[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_mode = M_SET;
        m_code.delete();
        m_entry.delete();
        m_fails = 0;
        m_left = 0;
        m_lock = 0; m_green = 1; m_blue = 0; m_red = 0;
    endtask

    task automatic model(input int k);
        bit dig = (k <= 9);
        bit ent = (k == 10);
        bit clr = (k == 11);
        case (m_mode)
            M_SET: begin
                if (dig && m_code.size() < CL) m_code.push_back(k);
                else if (clr) m_code.delete();
                else if (ent && m_code.size() == CL) begin
                    m_mode = M_CONF;
                    m_entry.delete();
                end
            end
            M_CONF: begin
                if (dig && m_entry.size() < CL) m_entry.push_back(k);
                else if (clr) begin
                    m_mode = M_SET;
                    m_code.delete();
                end else if (ent && m_entry.size() == CL) begin
                    if (same_code()) begin
                        m_mode = M_LOCKED;
                        m_lock = 1; m_blue = 1; m_green = 0;
                    end else begin
                        m_mode = M_SET;
                        m_code.delete();
                    end
                    m_entry.delete();
                end
            end
            M_LOCKED: begin
                if (dig && m_entry.size() < CL) m_entry.push_back(k);
                else if (clr) m_entry.delete();
                else if (ent && m_entry.size() == CL) begin
                    if (same_code()) begin
                        m_mode = M_SET;
                        m_code.delete();
                        m_lock = 0; m_green = 1; m_blue = 0; m_fails = 0;
                    end else begin
                        m_fails++;
                        if (m_fails == MF) begin
                            m_mode = M_OUT;
                            m_left = LC;
                            m_red = 1; m_blue = 0; m_lock = 1;
                        end
                    end
                    m_entry.delete();
                end
            end
            M_OUT: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_LOCKED;
                    m_fails = 0; m_red = 0; m_blue = 1;
                    m_entry.delete();
                end
            end
        endcase
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".lock"},  32'(lock),  32'(m_lock));
        cmp({tag, ".green"}, 32'(green), 32'(m_green));
        cmp({tag, ".blue"},  32'(blue),  32'(m_blue));
        cmp({tag, ".red"},   32'(red),   32'(m_red));
        cmp({tag, ".fails"}, 32'(fails), 32'(m_fails));
    endtask

    task automatic step(input int k);
        invalue = 4'(k);
        @(posedge clk);
        model(k);
        #1;
        invalue = 4'd13;
        check_model("step");
    endtask

    task automatic pin(input int a, input int b, input int c, input int d);
        step(a); step(b); step(c); step(d); step(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_model("reset");
    endtask

    int red_cnt;
    int r;

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        cmp("rst.lock", 32'(lock), 0);
        cmp("rst.green", 32'(green), 1);
        cmp("rst.fails", 32'(fails), 0);

        pin(1, 2, 3, 4);
        pin(1, 2, 3, 4);
        cmp("setlock.lock", 32'(lock), 1);
        cmp("setlock.blue", 32'(blue), 1);
        cmp("setlock.green", 32'(green), 0);

        pin(0, 0, 0, 0);
        cmp("fail1.fails", 32'(fails), 1);
        pin(1, 2, 3, 4);
        cmp("unlock.lock", 32'(lock), 0);
        cmp("unlock.green", 32'(green), 1);
        cmp("unlock.fails", 32'(fails), 0);

        pin(1, 2, 3, 4);
        pin(1, 2, 3, 5);
        cmp("confmis.lock", 32'(lock), 0);
        cmp("confmis.fails", 32'(fails), 0);
        pin(9, 9, 9, 9);
        pin(9, 9, 9, 9);
        cmp("relock.lock", 32'(lock), 1);

        pin(0, 0, 0, 0);
        pin(1, 1, 1, 1);
        pin(2, 2, 2, 2);
        cmp("lockout.red", 32'(red), 1);
        red_cnt = 1;
        pin(9, 9, 9, 9);
        red_cnt += 5;
        cmp("lockout.keys.lock", 32'(lock), 1);
        for (int i = 0; i < 40 && red; i++) begin
            step(13);
            if (red) red_cnt++;
        end
        cmp("lockout.duration", 32'(red_cnt), 32'(LC));
        pin(9, 9, 9, 9);
        cmp("postout.lock", 32'(lock), 0);

        step(1); step(2); step(10); step(11);
        step(5); step(6); step(7); step(8); step(9); step(10);
        step(12); step(14); step(15);
        pin(5, 6, 7, 8);
        cmp("edge.lock", 32'(lock), 1);

        pin(0, 0, 0, 0);
        pin(0, 0, 0, 1);
        pin(0, 0, 1, 0);
        step(13); step(13); step(13); step(13);
        cmp("midout.red", 32'(red), 1);
        do_reset();
        cmp("midrst.lock", 32'(lock), 0);
        cmp("midrst.green", 32'(green), 1);
        cmp("midrst.red", 32'(red), 0);
        cmp("midrst.fails", 32'(fails), 0);
        pin(4, 3, 2, 1);
        pin(4, 3, 2, 1);
        cmp("newcode.lock", 32'(lock), 1);

        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) do_reset();
            else if (r < 45) step(int'($urandom_range(0, 1)));
            else if (r < 60) step(10);
            else if (r < 64) step(11);
            else if (r < 90) step(13);
            else step(int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
